// File: rtl/uart_led_rx.sv
// uart_led_rx: 8N1 serial receiver that latches each good byte onto the LEDs.
// Also exposes a byte strobe and a framing-error strobe.
module uart_led_rx #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] leds,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  localparam logic [15:0] HALF_M1 = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  logic        rx_meta;
  logic        rxs;
  logic [2:0]  state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      leds      <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!rxs) begin
            cnt   <= '0;
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            // a high mid-start-bit is a line glitch, not a frame
            state   <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_M1) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= S_STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_M1) begin
            cnt <= '0;
            if (rxs) begin
              rx_valid <= 1'b1;
              rx_data  <= shreg;
              leds     <= shreg;
              state    <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_RECOVER;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_RECOVER: begin
          // hold off until the line returns high so a break is not a start
          if (rxs)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_led_rx.sv
// tb_uart_led_rx: directed frames against uart_led_rx at default parameters.
// Covers reset, single/back-to-back bytes, framing error, glitch, mid-frame reset.
module tb_uart_led_rx;

  localparam int CPB = 217;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] leds;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;

  int n_chk = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err = 0;
  int v0, e0;
  logic [7:0] vq[$];

  uart_led_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .leds      (leds),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid || frame_err)
      check("excl", {31'd0, rx_valid & frame_err}, 32'd0);
    if (rx_valid) begin
      n_valid++;
      vq.push_back(rx_data);
    end
    if (frame_err)
      n_err++;
  end

  function automatic logic [31:0] qat(input int i);
    return (vq.size() > i) ? {24'd0, vq[i]} : 32'hDEAD;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input int cpb);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (cpb) @(negedge clk);
    end
  endtask

  initial begin
    logic [9:0] f;
    // reset
    idle(5);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_leds", {24'd0, leds}, 32'h00);
    check("rst_data", {24'd0, rx_data}, 32'h00);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    idle(1000);
    check("idle_valid", n_valid, 0);
    check("idle_err", n_err, 0);

    // single byte
    vq.delete();
    send(8'hA5, 1'b1, CPB);
    idle(20);
    check("one_cnt", vq.size(), 1);
    check("one_data", qat(0), 32'hA5);
    check("one_leds", {24'd0, leds}, 32'hA5);
    idle(500);
    check("one_hold", {24'd0, leds}, 32'hA5);

    // back-to-back
    vq.delete();
    send(8'h00, 1'b1, CPB);
    send(8'hFF, 1'b1, CPB);
    send(8'h3C, 1'b1, CPB);
    idle(20);
    check("b2b_cnt", vq.size(), 3);
    check("b2b_0", qat(0), 32'h00);
    check("b2b_1", qat(1), 32'hFF);
    check("b2b_2", qat(2), 32'h3C);
    check("b2b_leds", {24'd0, leds}, 32'h3C);

    // framing error
    send(8'h55, 1'b1, CPB);
    idle(20);
    check("fe_pre", {24'd0, leds}, 32'h55);
    v0 = n_valid;
    e0 = n_err;
    send(8'h12, 1'b0, CPB);
    idle(3 * CPB);
    check("fe_err", n_err - e0, 1);
    check("fe_novalid", n_valid - v0, 0);
    check("fe_leds", {24'd0, leds}, 32'h55);
    check("fe_data", {24'd0, rx_data}, 32'h55);
    rx = 1'b1;
    idle(300);
    check("fe_quiet", (n_err - e0) + (n_valid - v0), 1);
    send(8'h81, 1'b1, CPB);
    idle(20);
    check("fe_next", {24'd0, leds}, 32'h81);

    // glitch
    v0 = n_valid;
    e0 = n_err;
    rx = 1'b0;
    idle(40);
    rx = 1'b1;
    idle(400);
    check("gl_quiet", (n_valid - v0) + (n_err - e0), 0);
    send(8'h0F, 1'b1, CPB);
    idle(20);
    check("gl_next", {24'd0, leds}, 32'h0F);

    // baud tolerance +/-2%
    send(8'h5A, 1'b1, 213);
    idle(20);
    check("fast_leds", {24'd0, leds}, 32'h5A);
    send(8'h6B, 1'b1, 221);
    idle(20);
    check("slow_leds", {24'd0, leds}, 32'h6B);

    // reset mid-frame during data bit 4
    v0 = n_valid;
    e0 = n_err;
    f = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx = f[5];
    idle(100);
    rst_n = 1'b0;
    #1;
    check("mr_leds", {24'd0, leds}, 32'h00);
    check("mr_data", {24'd0, rx_data}, 32'h00);
    check("mr_valid", {31'd0, rx_valid}, 32'd0);
    check("mr_ferr", {31'd0, frame_err}, 32'd0);
    rx = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(2000);
    check("mr_quiet", (n_valid - v0) + (n_err - e0), 0);
    check("mr_leds2", {24'd0, leds}, 32'h00);
    send(8'hC3, 1'b1, CPB);
    idle(20);
    check("mr_next", {24'd0, leds}, 32'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_led_rx.md
# uart_led_rx

UART receiver that lets a host drive the board LEDs remotely over a serial line. It samples an asynchronous 8N1 line, reassembles each byte and latches it straight onto the 8 LED outputs. It is the input-side counterpart of the on-board blink logic: the LED pattern comes from the host instead of a local timer. It sits between the board RX pin and the LED bank and also exposes a byte strobe and an error strobe for other consumers.

## Interface

- `CLK_FREQ`, default 25_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115_200: serial bit rate.
  - Derived `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` (integer division; 217 at defaults).
  - Derived `HALF_BIT = CLKS_PER_BIT / 2` (108 at defaults).

- `clk` input 1: system clock, all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `rx` input 1: serial line, idles high, asynchronous to `clk`.
- `leds` output 8: last correctly received byte; bit 0 = first data bit on the wire.
- `rx_data` output 8: received byte, valid while `rx_valid` = 1.
- `rx_valid` output 1: one-cycle strobe for a good frame.
- `frame_err` output 1: one-cycle strobe for a bad stop bit.

## Operation

- **Input synchronizer:** `rx` passes through a 2-flop synchronizer whose flops reset to 1. All decisions use the synchronized value `rxs`.
- **States:** IDLE, START, DATA, STOP, RECOVER. One 16-bit cycle counter and one 3-bit bit index.
- **IDLE:**
  - If `rxs` = 0, clear the counter and go to START.
  - Otherwise stay.
- **START:**
  - Count up to `HALF_BIT`-1, then sample `rxs`.
  - If 0, clear the counter and bit index and go to DATA.
  - If 1, treat it as a glitch and return to IDLE with no strobes.
- **DATA:**
  - Every `CLKS_PER_BIT` cycles, sample `rxs` into the shift register, LSB first.
  - After bit index 7 is sampled, go to STOP.
- **STOP:** after `CLKS_PER_BIT` cycles, sample `rxs`.
  - If 1: pulse `rx_valid`, load `rx_data` and `leds` with the byte, go to IDLE.
  - If 0: pulse `frame_err`, leave `leds` and `rx_data` unchanged, go to RECOVER.
- **RECOVER:** wait until `rxs` = 1, then go to IDLE. This covers break conditions and prevents a false restart.
- **Register behaviour:**
  - `leds` and `rx_data` hold their value between frames.
  - Only a good frame changes them.

## Timing

- **Reset values:** `leds` = 0x00, `rx_data` = 0x00, `rx_valid` = 0, `frame_err` = 0, state = IDLE, synchronizer flops = 1.
- **Reset behaviour:** reset takes effect immediately and asynchronously. Asserting it mid-frame discards the partial byte. After release, the block needs a high-to-low transition on `rxs` to start a new frame.
- **Sample points:** let t0 be the cycle IDLE sees `rxs` = 0.
  - Start-bit check at t0 + `HALF_BIT`.
  - Data bit i at t0 + `HALF_BIT` + (i+1)·`CLKS_PER_BIT`.
  - Stop bit at t0 + `HALF_BIT` + 9·`CLKS_PER_BIT`.
- **Output timing:** `rx_valid` or `frame_err`, `rx_data` and `leds` update on the cycle after the stop sample. Each strobe is high for exactly one cycle.
- **Latency at defaults:** start edge at the pin to `leds` update is 2 (synchronizer) + 108 + 9·217 + 1 cycles, about 2064 cycles.
- **Back-to-back frames:** the block returns to IDLE half a bit before the stop bit ends, so frames with no idle gap are received without loss.
- **Strobe exclusivity:** `rx_valid` and `frame_err` are never high together.
- **Baud tolerance:** at least ±2 % mismatch between transmitter and receiver must decode correctly.

## Test plan

- **Reset:** assert `rst_n` = 0 for 5 cycles with `rx` = 1, then release. Expect `leds` = 0x00, `rx_valid` = 0, `frame_err` = 0, and no strobes during 1000 idle cycles.
- **Single byte:** send 0xA5 at 115200 baud (217 cycles/bit). Expect exactly one `rx_valid` pulse with `rx_data` = 0xA5, and `leds` = 0xA5 held afterwards.
- **Back-to-back:** send 0x00, 0xFF, 0x3C with no idle gap. Expect three `rx_valid` pulses with data 0x00, 0xFF, 0x3C in order; final `leds` = 0x3C.
- **Framing error:**
  - Preload `leds` = 0x55 with a good frame.
  - Send 0x12 with stop bit = 0, holding `rx` low for a further 3 bit times before raising it. Expect one `frame_err` pulse, no `rx_valid`, `leds` still 0x55, and no further strobes until the line rises.
  - Then send 0x81. Expect `leds` = 0x81.
- **Glitch:** drive `rx` low for 40 cycles, then high. Expect no strobes and state back in IDLE; a following 0x0F frame is received correctly.
- **Reset mid-frame:** assert `rst_n` during data bit 4 of a frame. Expect all outputs to go to their reset values immediately, with no strobe for the aborted byte. A subsequent 0xC3 frame gives `leds` = 0xC3.
